// File: rtl/seq_add_sub.sv
// Multi-cycle ripple-carry adder/subtractor: SLICE bits per clock with a registered
// inter-slice carry, start/busy/done handshake, and carry/overflow/zero flags.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_r, y_r;
  logic             carry;
  logic [KW-1:0]    k;

  logic [SLICE-1:0] xs, ys;
  logic [SLICE:0]   sum;
  logic             msb_cin, last;
  logic [WIDTH-1:0] z_nxt;

  always_comb begin
    xs      = x_r[int'(k)*SLICE +: SLICE];
    ys      = y_r[int'(k)*SLICE +: SLICE];
    sum     = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, carry};
    // Carry into the slice's top bit recovered from the sum bit; on the last slice this is bit WIDTH-1.
    msb_cin = xs[SLICE-1] ^ ys[SLICE-1] ^ sum[SLICE-1];
    last    = (k == KW'(NSL - 1));
    z_nxt   = z;
    z_nxt[int'(k)*SLICE +: SLICE] = sum[SLICE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_r   <= '0;
      y_r   <= '0;
      carry <= 1'b0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            x_r   <= x;
            y_r   <= op ? ~y : y;
            carry <= op ? ~c_in : c_in;
            k     <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          z     <= z_nxt;
          carry <= sum[SLICE];
          k     <= k + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_out <= sum[SLICE];
            ovf   <= msb_cin ^ sum[SLICE];
            zero  <= (z_nxt == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: three instances (16/4, 8/8, 32/1) sharing operand
// inputs, each with its own start; hand-computed vectors plus a reference model.
module tb_seq_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic        op, c_in;
  logic [31:0] x, y;
  logic [2:0]  busy, done, c_out, ovf, zero;
  logic [15:0] z_a;
  logic [7:0]  z_b;
  logic [31:0] z_c;

  int n_assert = 0;
  int n_fail   = 0;
  int edges, bcnt;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(16), .SLICE(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op), .x(x[15:0]), .y(y[15:0]), .c_in(c_in),
    .busy(busy[0]), .done(done[0]), .z(z_a), .c_out(c_out[0]), .ovf(ovf[0]), .zero(zero[0]));
  seq_add_sub #(.WIDTH(8), .SLICE(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op), .x(x[7:0]), .y(y[7:0]), .c_in(c_in),
    .busy(busy[1]), .done(done[1]), .z(z_b), .c_out(c_out[1]), .ovf(ovf[1]), .zero(zero[1]));
  seq_add_sub #(.WIDTH(32), .SLICE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .op(op), .x(x), .y(y), .c_in(c_in),
    .busy(busy[2]), .done(done[2]), .z(z_c), .c_out(c_out[2]), .ovf(ovf[2]), .zero(zero[2]));

  function automatic logic [31:0] zv(input int i);
    case (i)
      0:       return {16'b0, z_a};
      1:       return {24'b0, z_b};
      default: return z_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sign-rule overflow model, independent of the carry-chain formulation.
  task automatic ref_model(input int w, input logic o, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, output logic [31:0] ez, output logic ec,
                           output logic eo, output logic ezr);
    logic [63:0] mask, am, ye, full;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'b0, a} & mask;
    ye   = o ? (~{32'b0, b} & mask) : ({32'b0, b} & mask);
    full = am + ye + {63'b0, (o ? ~ci : ci)};
    ez   = full[31:0] & mask[31:0];
    ec   = full[w];
    eo   = (am[w-1] == ye[w-1]) && (full[w-1] != am[w-1]);
    ezr  = (ez == 32'b0);
  endtask

  // Accepts a start on the next edge, scrambles operands, then waits (bounded) for done.
  task automatic run(input int i, input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input bit inject);
    x = a; y = b; op = o; c_in = ci; start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    x = $urandom; y = $urandom; op = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
    edges = 0; bcnt = 0;
    while (!done[i] && edges < 100) begin
      if (busy[i]) bcnt++;
      if (inject && edges == 1) begin
        start[i] = 1'b1; x = '1; y = '1;
      end else start[i] = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    start[i] = 1'b0;
  endtask

  task automatic expect_res(input int i, input string tag, input logic [31:0] ez, input logic ec,
                            input logic eo, input logic ezr, input int elat);
    chk({tag, "_lat"}, edges, elat);
    chk({tag, "_z"}, zv(i), ez);
    chk({tag, "_cout"}, {31'b0, c_out[i]}, {31'b0, ec});
    chk({tag, "_ovf"}, {31'b0, ovf[i]}, {31'b0, eo});
    chk({tag, "_zero"}, {31'b0, zero[i]}, {31'b0, ezr});
  endtask

  initial begin
    logic [31:0] a, b, ez;
    logic        o, ci, ec, eo, ezr;
    bit          seen;

    rst_n = 1'b0; start = '0; op = 1'b0; c_in = 1'b0; x = '0; y = '0;
    #12;
    chk("rst_busy", {29'b0, busy}, 0);
    chk("rst_done", {29'b0, done}, 0);
    chk("rst_z_a", {16'b0, z_a}, 0);
    chk("rst_flags", {26'b0, c_out, ovf, zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed overflow on add, latency and busy width
    run(0, 1'b0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    chk("add_busy_cycles", bcnt, 4);
    expect_res(0, "add_ovf", 32'h8000, 1'b0, 1'b1, 1'b0, 4);
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done[0]}, 0);
    chk("z_hold_idle", {16'b0, z_a}, 32'h8000);

    run(0, 1'b1, 32'h0005, 32'h0005, 1'b0, 1'b0);
    expect_res(0, "sub_eq", 32'h0000, 1'b1, 1'b0, 1'b1, 4);
    @(posedge clk); #1;
    run(0, 1'b1, 32'h0000, 32'h0001, 1'b0, 1'b0);
    expect_res(0, "sub_neg", 32'hFFFF, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk); #1;

    run(0, 1'b0, 32'hFFFF, 32'h0000, 1'b1, 1'b0);
    expect_res(0, "add_cin", 32'h0000, 1'b1, 1'b0, 1'b1, 4);
    @(posedge clk); #1;
    run(0, 1'b1, 32'h8000, 32'h0000, 1'b1, 1'b0);
    expect_res(0, "sub_bin", 32'h7FFF, 1'b1, 1'b1, 1'b0, 4);
    @(posedge clk); #1;

    // start during RUN must be ignored
    run(0, 1'b0, 32'h1234, 32'h1111, 1'b0, 1'b1);
    expect_res(0, "busy_start", 32'h2345, 1'b0, 1'b0, 1'b0, 4);
    // start held in the DONE cycle: next op begins without an IDLE cycle
    chk("in_done", {31'b0, done[0]}, 1);
    run(0, 1'b0, 32'h0003, 32'h0004, 1'b0, 1'b0);
    expect_res(0, "b2b", 32'h0007, 1'b0, 1'b0, 1'b0, 4);

    // Asynchronous reset two cycles into RUN
    x = 32'h7FFF; y = 32'h0001; op = 1'b0; c_in = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", {31'b0, busy[0]}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_done", {30'b0, busy[0], done[0]}, 0);
    chk("arst_z", {16'b0, z_a}, 0);
    chk("arst_flags", {29'b0, c_out[0], ovf[0], zero[0]}, 0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) seen = 1'b1;
    end
    chk("arst_no_done", {31'b0, seen}, 0);
    run(0, 1'b0, 32'h0102, 32'h0304, 1'b0, 1'b0);
    expect_res(0, "post_rst", 32'h0406, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk); #1;

    // Single-pass 8-bit instance
    run(1, 1'b0, 32'h7F, 32'h01, 1'b0, 1'b0);
    expect_res(1, "w8_ovf", 32'h80, 1'b0, 1'b1, 1'b0, 1);
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) begin
      a = $urandom; b = $urandom; o = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      ref_model(8, o, a, b, ci, ez, ec, eo, ezr);
      run(1, o, a, b, ci, 1'b0);
      expect_res(1, "w8_rand", ez, ec, eo, ezr, 1);
    end
    @(posedge clk); #1;

    // Bit-serial 32-bit instance
    run(2, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    expect_res(2, "w32_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32);
    for (int n = 0; n < 4; n++) begin
      a = $urandom; b = $urandom; o = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      ref_model(32, o, a, b, ci, ez, ec, eo, ezr);
      run(2, o, a, b, ci, 1'b0);
      expect_res(2, "w32_rand", ez, ec, eo, ezr, 32);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
